// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, command record and sequencer states for the ALU front end
package alu_pkg;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_AND     = 3'b010;
  localparam logic [2:0] OP_OR      = 3'b011;
  localparam logic [2:0] OP_LT      = 3'b100;
  localparam logic [2:0] OP_ADD_ACC = 3'b101;
  localparam logic [2:0] OP_AND_ACC = 3'b110;
  localparam logic [2:0] OP_OR_ACC  = 3'b111;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [15:0] x;
    logic [15:0] y;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - DEPTH-entry synchronous command FIFO; push/pop are ignored when full/empty
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  alu_cmd_t wdata,
  output alu_cmd_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  alu_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - buffers ALU commands, issues one at a time and returns the captured result
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_opcode,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  output logic        alu_enable,
  output logic [2:0]  alu_opcode,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  input  logic [15:0] alu_results,
  input  logic        alu_cf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_opcode,
  output logic [15:0] out_results,
  output logic        out_cf,
  output logic        busy
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  seq_state_t     state;
  logic [CW-1:0]  wait_cnt;
  alu_cmd_t       head;
  alu_cmd_t       wcmd;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;

  assign wcmd     = '{opcode: in_opcode, x: in_x, y: in_y};
  assign in_ready = !fifo_full;
  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign busy     = (state != ST_IDLE) || !fifo_empty;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (in_valid),
    .pop   (pop),
    .wdata (wcmd),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      alu_enable  <= 1'b0;
      alu_opcode  <= '0;
      alu_x       <= '0;
      alu_y       <= '0;
      out_valid   <= 1'b0;
      out_opcode  <= '0;
      out_results <= '0;
      out_cf      <= 1'b0;
    end else begin
      alu_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_opcode <= head.opcode;
            alu_x      <= head.x;
            alu_y      <= head.y;
            // NOPs are answered locally and never reach the ALU.
            if (head.opcode == OP_NOP) begin
              out_opcode  <= OP_NOP;
              out_results <= '0;
              out_cf      <= 1'b0;
              out_valid   <= 1'b1;
              state       <= ST_RESP;
            end else begin
              alu_enable <= 1'b1;
              state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt <= CW'(ALU_LAT - 1);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            out_opcode  <= alu_opcode;
            out_results <= alu_results;
            out_cf      <= alu_cf;
            out_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard bench with a behavioural ALU and reference model
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic        CLK, RST_N;
  logic        in_valid, in_ready;
  logic [2:0]  in_opcode;
  logic [15:0] in_x, in_y;
  logic        alu_enable;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_x, alu_y;
  logic [15:0] alu_results;
  logic        alu_cf;
  logic        out_valid, out_ready;
  logic [2:0]  out_opcode;
  logic [15:0] out_results;
  logic        out_cf;
  logic        busy;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_x(in_x), .in_y(in_y),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_x(alu_x), .alu_y(alu_y),
    .alu_results(alu_results), .alu_cf(alu_cf),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_results(out_results), .out_cf(out_cf), .busy(busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] res;
    logic        cf;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          en_cnt = 0;
  int          nonnop_cnt = 0;
  int          rdy_mode = 0;
  logic [15:0] ref_acc = '0;
  logic [15:0] alu_acc = '0;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // What a 16-bit ALU with a private accumulator returns for one command.
  task automatic alu_eval(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] acc_in, output logic [15:0] acc_out,
                          output logic [16:0] rv);
    logic [16:0] s;
    acc_out = acc_in;
    case (op)
      OP_ADD:     rv = {1'b0, x} + {1'b0, y};
      OP_AND:     rv = {1'b0, x & y};
      OP_OR:      rv = {1'b0, x | y};
      OP_LT:      rv = (x < y) ? 17'h10001 : 17'h00000;
      OP_ADD_ACC: begin s = {1'b0, acc_in} + {1'b0, x}; acc_out = s[15:0]; rv = s; end
      OP_AND_ACC: begin acc_out = acc_in & x; rv = {1'b0, acc_in & x}; end
      OP_OR_ACC:  begin acc_out = acc_in | x; rv = {1'b0, acc_in | x}; end
      default:    rv = '0;
    endcase
  endtask

  // Behavioural ALU: samples Enable and presents the result ALU_LAT cycles later.
  initial begin
    logic [16:0] rv;
    logic [15:0] na;
    logic [2:0]  op;
    logic [15:0] x, y;
    alu_results = 16'hDEAD;
    alu_cf      = 1'b1;
    forever begin
      @(negedge CLK);
      if (alu_enable && RST_N) begin
        op = alu_opcode; x = alu_x; y = alu_y;
        alu_eval(op, x, y, alu_acc, na, rv);
        alu_acc = na;
        @(posedge CLK);
        repeat (ALU_LAT - 1) @(posedge CLK);
        #1;
        alu_results = rv[15:0];
        alu_cf      = rv[16];
      end
    end
  end

  initial begin
    out_ready = 0;
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: response ordering, out_* stability under back-pressure, Enable pulse shape.
  initial begin
    logic        hold_v, prev_en;
    logic [19:0] hold_val;
    exp_t        e;
    hold_v = 0; prev_en = 0; hold_val = '0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        hold_v = 0; prev_en = 0;
      end else begin
        if (alu_enable) begin
          en_cnt++;
          check("enable_single_cycle", 36'(prev_en), 36'(0));
        end
        prev_en = alu_enable;
        if (hold_v) begin
          check("out_valid_held", 36'(out_valid), 36'(1));
          check("out_stable", 36'({out_opcode, out_results, out_cf}), 36'(hold_val));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp actual=op%0d res=%h required=none", out_opcode, out_results);
          end else begin
            e = exp_q.pop_front();
            check("resp_opcode", 36'(out_opcode), 36'(e.op));
            check("resp_results", 36'(out_results), 36'(e.res));
            check("resp_cf", 36'(out_cf), 36'(e.cf));
          end
        end
        hold_v   = out_valid && !out_ready;
        hold_val = {out_opcode, out_results, out_cf};
      end
    end
  end

  task automatic push(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] rv;
    logic [15:0] na;
    bit          done = 0;
    in_valid = 1; in_opcode = op; in_x = x; in_y = y;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge CLK);
      if (in_ready) begin
        @(posedge CLK);
        done = 1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL push_timeout actual=stalled required=accepted op=%0d", op);
    end else begin
      alu_eval(op, x, y, ref_acc, na, rv);
      ref_acc = na;
      exp_q.push_back('{op: op, res: rv[15:0], cf: rv[16]});
      if (op != OP_NOP) nonnop_cnt++;
    end
    #1 in_valid = 0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !busy && !out_valid) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    int en0;
    RST_N = 0; in_valid = 0; in_opcode = '0; in_x = '0; in_y = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_in_ready", 36'(in_ready), 36'(1));
    check("rst_busy", 36'(busy), 36'(0));
    check("rst_alu", 36'({alu_enable, alu_opcode, alu_x, alu_y}), 36'(0));
    check("rst_out", 36'({out_valid, out_opcode, out_results, out_cf}), 36'(0));
    RST_N = 1;
    @(posedge CLK); #1;

    // ADD latency: out_valid appears exactly after edge 3.
    rdy_mode = 0;
    push(OP_ADD, 16'hFFFF, 16'h0001);
    @(posedge CLK); #1;
    check("add_enable_e1", 36'(alu_enable), 36'(1));
    check("add_valid_e1", 36'(out_valid), 36'(0));
    @(posedge CLK); #1;
    check("add_enable_e2", 36'(alu_enable), 36'(0));
    check("add_valid_e2", 36'(out_valid), 36'(0));
    @(posedge CLK); #1;
    check("add_valid_e3", 36'(out_valid), 36'(1));
    rdy_mode = 1;
    drain();

    push(OP_LT, 16'd3, 16'd5);
    push(OP_AND, 16'h0F0F, 16'h00FF);
    drain();

    // NOP answered after one edge with no ALU pulse.
    rdy_mode = 0;
    en0 = en_cnt;
    push(OP_NOP, 16'h5555, 16'hAAAA);
    @(posedge CLK); #1;
    check("nop_valid_e1", 36'(out_valid), 36'(1));
    check("nop_no_enable", 36'(en_cnt - en0), 36'(0));
    rdy_mode = 1;
    push(OP_OR, 16'h1200, 16'h0034);
    drain();
    check("nop_or_enables", 36'(en_cnt - en0), 36'(1));

    // Back-pressure for more than 10 cycles in RESP.
    rdy_mode = 0;
    en0 = en_cnt;
    push(OP_ADD, 16'($urandom), 16'($urandom));
    repeat (14) @(posedge CLK);
    #1;
    check("bp_valid", 36'(out_valid), 36'(1));
    check("bp_one_enable", 36'(en_cnt - en0), 36'(1));
    rdy_mode = 1;
    drain();

    // Fill: one in flight plus DEPTH buffered, then one more stalls.
    rdy_mode = 0;
    for (int i = 0; i < DEPTH + 1; i++) push(3'($urandom_range(0, 4)), 16'($urandom), 16'($urandom));
    check("full_in_ready", 36'(in_ready), 36'(0));
    fork
      push(OP_ADD, 16'h00F0, 16'h000F);
      begin
        repeat (5) @(posedge CLK);
        #1;
        check("full_stall_hold", 36'(in_ready), 36'(0));
        rdy_mode = 1;
      end
    join
    drain();

    // Reset while waiting on the ALU discards the command.
    rdy_mode = 1;
    push(OP_ADD, 16'h1111, 16'h2222);
    @(posedge CLK);
    @(posedge CLK); #1;
    check("wait_busy", 36'(busy), 36'(1));
    RST_N = 0;
    #1;
    exp_q.delete();
    check("arst_in_ready", 36'(in_ready), 36'(1));
    check("arst_busy", 36'(busy), 36'(0));
    check("arst_alu", 36'({alu_enable, alu_opcode, alu_x, alu_y}), 36'(0));
    check("arst_out", 36'({out_valid, out_opcode, out_results, out_cf}), 36'(0));
    @(posedge CLK); #1;
    RST_N = 1;
    repeat (10) @(posedge CLK);
    #1;
    check("post_rst_valid", 36'(out_valid), 36'(0));

    // Randomized mix with random consumer back-pressure.
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      push(3'($urandom), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end
    drain();
    check("enable_total", 36'(en_cnt), 36'(nonnop_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side front end for the 16-bit ALU. Accepts (opcode, X, Y) commands over a valid/ready handshake and buffers them in a small FIFO. Issues each command to the ALU as a single-cycle Enable pulse, waits the ALU's fixed latency, then returns Results/CF over a valid/ready response port. It sits between the test/control logic and the ALU, and is the only agent allowed to drive the ALU's Enable, X, Y and Opcode.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- ALU_LAT, 1: cycles from the Enable edge until ALU Results/CF are stable; at least 1.

Ports:
- CLK  in  1  single clock; all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  FIFO not full.
- in_opcode  in  3  ALU opcode: 000 NOP, 001 ADD, 010 AND, 011 OR, 100 LT, 101 ADD-acc, 110 AND-acc, 111 OR-acc.
- in_x, in_y  in  16  operands.
- alu_enable  out  1  Enable to the ALU; one-cycle pulse per issued command.
- alu_opcode  out  3  opcode to the ALU.
- alu_x, alu_y  out  16  operands to the ALU.
- alu_results  in  16  ALU Results.
- alu_cf  in  1  ALU CF.
- out_valid  out  1  response available.
- out_ready  in  1  consumer accepts the response.
- out_opcode  out  3  opcode of the completed command.
- out_results  out  16  captured Results.
- out_cf  out  1  captured CF.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

## Operation
- Reset values: alu_enable, alu_opcode, alu_x, alu_y, out_valid, out_opcode, out_results, out_cf and busy are all 0. in_ready is 1. The FIFO is empty and the FSM is in IDLE.
- Push: on in_valid && in_ready. in_ready = !full.
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- IDLE, FIFO non-empty:
  - Pop the head entry and register it onto alu_opcode/alu_x/alu_y.
  - If the opcode is NOP, load out_results=0, out_cf=0 and out_valid=1, then go to RESP. The ALU is never enabled for a NOP.
  - Otherwise, go to ISSUE.
- ISSUE: alu_enable=1 for exactly this cycle. Load the wait counter with ALU_LAT-1 and go to WAIT.
- WAIT: decrement the counter. When it is 0, capture alu_results and alu_cf into the out_* registers, set out_valid=1 and go to RESP.
- RESP: hold all out_* stable while out_valid && !out_ready. On out_ready, clear out_valid and go to IDLE.
- alu_x, alu_y and alu_opcode hold their values until the next pop.
- Only one command is in flight. The FIFO keeps accepting commands during ISSUE, WAIT and RESP.
- Accumulate opcodes (101–111) get no special handling: the ALU owns the accumulator. The sequencer only guarantees strict in-order issue.
- Push and pop in the same cycle are legal at any occupancy below full; the count is unchanged. At full, in_ready=0, so no push occurs. Pointers wrap modulo DEPTH.
- Reset asserted mid-operation (any state) returns every output to its reset value immediately and asynchronously. The FIFO is flushed and the in-flight command is discarded with no response.

## Timing
- Non-NOP latency, with the command accepted at edge 0 into an empty FIFO and an idle FSM:
  - edge 1: pop and enter ISSUE.
  - edge 2: the ALU samples Enable.
  - edge 2+ALU_LAT: capture and assert out_valid.
  - With the default ALU_LAT=1, out_valid is high after edge 3.
- NOP latency: out_valid is high after edge 1.
- Throughput with out_ready held high: one non-NOP command per 3+ALU_LAT cycles (ISSUE, ALU_LAT WAIT cycles, RESP, IDLE).
- in_ready depends combinationally only on the FIFO count, never on in_valid.
- out_valid never drops without a handshake.

## Structure
- Package alu_pkg holds:
  - the opcode localparams (OP_NOP through OP_OR_ACC);
  - the packed command typedef {opcode[2:0], x[15:0], y[15:0]};
  - the FSM state enum.
- Sub-module alu_cmd_fifo: a DEPTH-entry synchronous FIFO of that typedef, with push/pop/full/empty and an async active-low reset. The FSM and the output registers live in the top module.

## Test plan
- ADD: X=0xFFFF, Y=0x0001, opcode 001 -> after 3 cycles out_results=0x0000, out_cf=1, out_opcode=001. alu_enable is high for exactly 1 cycle.
- LT then AND: LT with X=3, Y=5, then AND with X=0x0F0F, Y=0x00FF -> responses in order: first 0x0001 with cf=1, then 0x000F with cf=0.
- FIFO full: hold out_ready=0 and push DEPTH+1 commands. Expected:
  - in_ready drops after the FIFO fills;
  - the stalled command is accepted once a response drains;
  - all responses come out in order.
- Back-pressure: hold out_ready=0 for 10 cycles during RESP -> out_* stays stable and no second alu_enable pulse occurs.
- NOP mix: NOP, then OR with X=0x1200, Y=0x0034 -> the NOP response (0x0000, cf=0) arrives with no ALU pulse; then 0x1234 with cf=0.
- Reset mid-WAIT: assert RST_N=0 while in WAIT -> all outputs return to 0 (in_ready to 1) in the same cycle. No response follows after reset is released.
